deal_hand: RTL and testbench
============================

Name: deal_hand

Overview:
- Produces the packed 7-card hands consumed by the rank sorter. It is the producer end of the 42-bit card interface.
- Pseudo-randomly deals 9 unique cards from a 52-card deck using a 16-bit LFSR:
  - hole cards A1, B1, A2, B2, then community C1..C5.
- Packs player A's hand (2 hole + 5 community) and player B's hand into two 42-bit vectors. Each vector feeds one sorter instance.
- Sits between the game controller (start, seed) and the two sorters.

Parameters:
SEED_DEFAULT  16'hACE1  LFSR value after reset; also substituted whenever a zero seed is loaded.

Ports:
clk         input   1   system clock; all logic on rising edge
rst_n       input   1   synchronous active-low reset
seed_load   input   1   load seed into LFSR (honoured in IDLE/DONE only)
seed        input   16  seed value
start       input   1   begin a new deal (honoured in IDLE/DONE only)
busy        output  1   1 while in DRAW
hand_valid  output  1   1 while in DONE; hands stable
hand_a      output  42  player A hand: [5:0]=A1, [11:6]=A2, [17:12]=C1 ... [41:36]=C5
hand_b      output  42  player B hand: [5:0]=B1, [11:6]=B2, [17:12]=C1 ... [41:36]=C5

Behaviour:
- Card code (6 bits):
  - [3:0] rank, 2..14, where 14 = ace. Codes 0, 1, 15 are invalid.
  - [5:4] suit, 0..3.
  - This matches the sorter's rank compare on [3:0].
- LFSR, Fibonacci: fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}.
  - Advances every cycle in DRAW only; holds otherwise.
- Reset (rst_n=0 at an edge):
  - state=IDLE, lfsr=SEED_DEFAULT, used mask (64 bits, indexed by raw code)=0, count=0.
  - busy=0, hand_valid=0, hand_a=0, hand_b=0.
  - Reset overrides all inputs and aborts a deal in progress; no partial hand is ever presented.
- IDLE/DONE:
  - seed_load=1: lfsr <= (seed==0 ? SEED_DEFAULT : seed).
  - start=1: used<=0, count<=0, hand_valid<=0, state<=DRAW.
  - If seed_load and start are both 1 in the same cycle, the seed load takes effect and the deal starts. The first candidate is drawn from the new seed.
  - hand_a/hand_b hold their previous values until overwritten.
- DRAW, each cycle:
  - candidate = lfsr[5:0], evaluated before the shift.
  - Accept iff rank in 2..14 and used[candidate]==0.
  - On accept: slot[count]<=candidate, used[candidate]<=1, count<=count+1.
  - On reject: count unchanged.
  - start and seed_load are ignored.
- Completion:
  - At the edge that accepts the 9th card (count 8->9): state<=DONE, busy<=0, hand_valid<=1.
  - hand_a and hand_b are loaded at that same edge; the 9th card is muxed in directly.
  - Slot mapping:
    - slot0=A1, slot1=B1, slot2=A2, slot3=B2, slot4..8=C1..C5.
- Latency:
  - busy rises the edge after start is sampled.
  - Minimum deal time is 9 DRAW cycles; the actual count depends on rejects.
  - No timeout is required: the maximal-period LFSR covers every 6-bit pattern with a non-zero upper part repeatedly.
- The 9 dealt codes are pairwise distinct and all valid. hand_a and hand_b share identical bits [41:12].

Test Plan:
1. Reset check: hold rst_n=0 for 3 cycles with start=1 -> busy=0, hand_valid=0, hand_a=hand_b=0. After release, the internal LFSR equals 16'hACE1 (checked via bench model of first candidate).
2. Seed 16'h0000 loaded then start -> identical hands to a deal after reset with no seed load (zero-seed substitution).
3. seed=16'h1234, start -> busy high from the next cycle. hand_valid rises exactly when the bench LFSR model accepts its 9th card. hand_a/hand_b match the model slot mapping bit-for-bit. 9 codes distinct, ranks 2..14.
4. Pulse start and seed_load=1/seed=16'hFFFF mid-DRAW -> both ignored. Result equals an undisturbed deal from the original seed.
5. Deassert rst_n mid-DRAW after 4 accepts -> next edge shows busy=0, hand_valid=0, hands=0. A new start deals 9 fresh cards from SEED_DEFAULT.
6. 1000 back-to-back deals, with start asserted on the first DONE cycle each time -> every deal yields 9 distinct valid codes and hand_a[41:12]==hand_b[41:12]. hand_valid drops the cycle after each start.

Source files
------------

// File: rtl/deal_hand.sv
`default_nettype none
// ============================================================================
// Module      : deal_hand
// Description : Deals 9 unique cards from a 52-card deck using a 16-bit
//               Fibonacci LFSR and packs two 7-card hands (2 hole cards plus
//               5 shared community cards) for the downstream rank sorters.
// Ports       : clk        - system clock, rising edge
//               rst_n      - synchronous active-low reset
//               seed_load  - load seed into LFSR (IDLE/DONE only)
//               seed       - 16-bit seed value (zero maps to SEED_DEFAULT)
//               start      - begin a new deal (IDLE/DONE only)
//               busy       - high while drawing
//               hand_valid - high while hands are complete and stable
//               hand_a     - {C5,C4,C3,C2,C1,A2,A1}, 6 bits per card
//               hand_b     - {C5,C4,C3,C2,C1,B2,B1}, 6 bits per card
// Revision    : 1.0 - initial release
// ============================================================================
module deal_hand #(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        start,
  output logic        busy,
  output logic        hand_valid,
  output logic [41:0] hand_a,
  output logic [41:0] hand_b
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [63:0] used;       // one bit per raw 6-bit card code
  logic [3:0]  count;      // cards accepted so far, 0..9
  logic [5:0]  slot [0:7]; // first 8 accepted cards; the 9th is muxed in directly

  logic [5:0]  cand;
  logic        rank_ok;
  logic        accept;
  logic        feedback;

  assign cand     = lfsr[5:0];
  assign rank_ok  = (cand[3:0] >= 4'd2) && (cand[3:0] <= 4'd14);
  assign accept   = rank_ok && !used[cand];
  assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr       <= SEED_DEFAULT;
      used       <= 64'd0;
      count      <= 4'd0;
      busy       <= 1'b0;
      hand_valid <= 1'b0;
      hand_a     <= 42'd0;
      hand_b     <= 42'd0;
      for (int i = 0; i < 8; i++) begin
        slot[i] <= 6'd0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (seed_load) begin
            lfsr <= (seed == 16'd0) ? SEED_DEFAULT : seed;
          end
          if (start) begin
            used       <= 64'd0;
            count      <= 4'd0;
            hand_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= DRAW;
          end
        end

        DRAW: begin
          lfsr <= {lfsr[14:0], feedback};
          if (accept) begin
            used[cand] <= 1'b1;
            count      <= count + 4'd1;
            if (count < 4'd8) begin
              slot[count[2:0]] <= cand;
            end else begin
              // 9th card: publish both hands on this same edge
              state      <= DONE;
              busy       <= 1'b0;
              hand_valid <= 1'b1;
              hand_a     <= {cand, slot[7], slot[6], slot[5], slot[4], slot[2], slot[0]};
              hand_b     <= {cand, slot[7], slot[6], slot[5], slot[4], slot[3], slot[1]};
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_deal_hand.sv
`default_nettype none
// ============================================================================
// Module      : tb_deal_hand
// Description : Directed self-checking bench for deal_hand. A reference
//               model of the LFSR deal predicts every hand and its timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deal_hand;

  logic        clk;
  logic        rst_n;
  logic        seed_load;
  logic [15:0] seed;
  logic        start;
  logic        busy;
  logic        hand_valid;
  logic [41:0] hand_a;
  logic [41:0] hand_b;

  int n_cmp;
  int n_bad;

  logic [15:0] m_lfsr;   // model copy of the DUT LFSR
  logic [41:0] last_a;
  logic [41:0] last_b;
  logic [41:0] a0, b0, a3, b3;

  deal_hand dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_load  (seed_load),
    .seed       (seed),
    .start      (start),
    .busy       (busy),
    .hand_valid (hand_valid),
    .hand_a     (hand_a),
    .hand_b     (hand_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference deal: returns packed hands, DRAW cycles needed, cycle of the
  // 4th accept, and the LFSR value left after the deal.
  task automatic model_deal(input logic [15:0] l_in,
                            output logic [41:0] ea, output logic [41:0] eb,
                            output int ncyc, output int k4,
                            output logic [15:0] l_out);
    logic [15:0] l;
    logic [63:0] seen;
    logic [5:0]  c;
    logic [5:0]  s [0:8];
    int          got;
    l = l_in; seen = '0; got = 0; ncyc = 0; k4 = 0;
    while (got < 9) begin
      c = l[5:0];
      ncyc++;
      if (c[3:0] >= 2 && c[3:0] <= 14 && !seen[c]) begin
        seen[c] = 1'b1;
        s[got] = c;
        got++;
        if (got == 4) k4 = ncyc;
      end
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    l_out = l;
    ea = {s[8], s[7], s[6], s[5], s[4], s[2], s[0]};
    eb = {s[8], s[7], s[6], s[5], s[4], s[3], s[1]};
  endtask

  function automatic bit hand_ok(input logic [41:0] a, input logic [41:0] b);
    logic [63:0] m;
    logic [5:0]  c [0:8];
    bit          ok;
    c[0] = a[5:0]; c[1] = b[5:0]; c[2] = a[11:6]; c[3] = b[11:6];
    for (int i = 0; i < 5; i++) c[4+i] = a[12+6*i +: 6];
    m = '0; ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (c[i][3:0] < 2 || c[i][3:0] > 14 || m[c[i]]) ok = 1'b0;
      m[c[i]] = 1'b1;
    end
    return ok;
  endfunction

  task automatic do_deal(input bit load, input logic [15:0] sd, input bit disturb);
    logic [41:0] ea, eb;
    logic [15:0] nl;
    int          n, k4;
    if (load) m_lfsr = (sd == 16'd0) ? 16'hACE1 : sd;
    model_deal(m_lfsr, ea, eb, n, k4, nl);
    m_lfsr = nl;
    start = 1'b1; seed_load = load; seed = sd;
    step();
    start = 1'b0; seed_load = 1'b0;
    check("busy_rise", busy, 1);
    check("hv_drop", hand_valid, 0);
    for (int i = 1; i < n; i++) begin
      if (disturb && i == 2) begin
        start = 1'b1; seed_load = 1'b1; seed = 16'hFFFF;
      end
      step();
      start = 1'b0; seed_load = 1'b0;
    end
    check("hv_early", hand_valid, 0);
    check("busy_hold", busy, 1);
    step();
    check("hv_done", hand_valid, 1);
    check("busy_done", busy, 0);
    check("hand_a", hand_a, ea);
    check("hand_b", hand_b, eb);
    check("cards_ok", hand_ok(hand_a, hand_b), 1);
    check("shared", hand_a[41:12], hand_b[41:12]);
    last_a = hand_a; last_b = hand_b;
  endtask

  initial begin
    logic [41:0] ea, eb;
    logic [15:0] nl;
    int          n, k4;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; seed_load = 1'b0; seed = 16'd0; start = 1'b1;

    // 1: reset dominates start
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_hv", hand_valid, 0);
    check("rst_a", hand_a, 0);
    check("rst_b", hand_b, 0);
    rst_n = 1'b1; start = 1'b0;
    step();
    m_lfsr = 16'hACE1;
    do_deal(1'b0, 16'd0, 1'b0);
    a0 = last_a; b0 = last_b;

    // 2: zero seed substitutes the default
    seed_load = 1'b1; seed = 16'h0000;
    step();
    seed_load = 1'b0;
    m_lfsr = 16'hACE1;
    do_deal(1'b0, 16'd0, 1'b0);
    check("zseed_a", last_a, a0);
    check("zseed_b", last_b, b0);

    // 3: explicit seed
    do_deal(1'b1, 16'h1234, 1'b0);
    a3 = last_a; b3 = last_b;

    // 4: start/seed_load mid-draw are ignored
    do_deal(1'b1, 16'h1234, 1'b1);
    check("dist_a", last_a, a3);
    check("dist_b", last_b, b3);

    // 5: reset mid-draw after 4 accepts
    m_lfsr = 16'hBEEF;
    model_deal(m_lfsr, ea, eb, n, k4, nl);
    start = 1'b1; seed_load = 1'b1; seed = 16'hBEEF;
    step();
    start = 1'b0; seed_load = 1'b0;
    repeat (k4) step();
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_hv", hand_valid, 0);
    check("abort_a", hand_a, 0);
    check("abort_b", hand_b, 0);
    m_lfsr = 16'hACE1;
    do_deal(1'b0, 16'd0, 1'b0);
    check("post_rst_a", last_a, a0);

    // 6: back-to-back deals, start on the first DONE cycle
    for (int d = 0; d < 1000; d++) begin
      do_deal(1'b0, 16'd0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
